// File: rtl/ivld_pkg.sv
// Shared helpers for the input-valid scalar register.
// Pointer sizing and buffer depth legality.
package ivld_pkg;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit depth_ok(input int unsigned depth);
      return (depth >= 1) && (depth <= 8) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/ivld_fifo.sv
// Circular argument buffer: storage, wrapping pointers, occupancy.
// Callers gate push on space and pop on occupancy.
module ivld_fifo
   import ivld_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic [CW-1:0]         count_o
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_q, wr_d;
   logic [PW-1:0]         rd_q, rd_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
      if (pop_i)  rd_d = (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Contents are don't-care after reset, so storage has no reset.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/ivld_reg.sv
// Input-valid scalar register: buffers adapter arguments and retires
// the head on each rising ap_ready of the accelerator.
module ivld_reg
   import ivld_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  vld_in,
   output logic                  rdy_out,
   input  logic                  ap_start,
   input  logic                  ap_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  vld_out,
   output logic [CW-1:0]         count,
   output logic                  err_missing,
   output logic                  err_underflow
);

   localparam bit DepthOk = depth_ok(DEPTH);
   localparam logic [CW-1:0] Full = CW'(DEPTH);

   if (!DepthOk) begin : g_bad_depth
      $error("ivld_reg: DEPTH must be a power of two in 1..8");
   end

   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic [CW-1:0]         cnt;
   logic                  ap_start_q, ap_ready_q, init_q;
   logic                  err_missing_q, err_missing_d;
   logic                  err_underflow_q, err_underflow_d;
   logic                  empty, push, pop, rise_ready, rise_start;

   assign empty   = (cnt == '0);
   assign rdy_out = (cnt != Full);
   assign push    = vld_in & rdy_out;

   // The first sample after reset only reloads the edge registers,
   // so a level held high through reset is never seen as a rise.
   assign rise_ready = ap_ready & ~ap_ready_q & ~init_q;
   assign rise_start = ap_start & ~ap_start_q & ~init_q;
   assign pop        = rise_ready & ~empty;

   ivld_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CW         (CW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (data_in),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (cnt)
   );

   always_comb begin
      last_d          = last_q;
      err_missing_d   = err_missing_q;
      err_underflow_d = err_underflow_q;
      if (pop) last_d = head;
      if (rise_ready & empty) err_underflow_d = 1'b1;
      if (rise_start & empty & ~push) err_missing_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ap_start_q      <= 1'b0;
         ap_ready_q      <= 1'b0;
         init_q          <= 1'b1;
         last_q          <= '0;
         err_missing_q   <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         ap_start_q      <= ap_start;
         ap_ready_q      <= ap_ready;
         init_q          <= 1'b0;
         last_q          <= last_d;
         err_missing_q   <= err_missing_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign vld_out       = ~empty;
   assign data_out      = empty ? last_q : head;
   assign count         = cnt;
   assign err_missing   = err_missing_q;
   assign err_underflow = err_underflow_q;

endmodule
